// File: rtl/wb_commit_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_commit_arbiter
// Purpose  : Shares the single GPR write port between the execute unit
//            (ALU/CSR results) and the load/store unit (load returns).
//            Emits one registered commit record per retired instruction and
//            halts the core when an ebreak from the execute unit commits.
//            Fixed priority favours LSU; a saturating starvation counter
//            hands priority to EXU after STARVE_LIMIT stalled cycles.
// Ports    : clk, rst                - clock, asynchronous active-high reset
//            exu_* / lsu_*           - valid/ready write-back requests
//            exu_break               - EXU instruction is ebreak
//            rf_wen/waddr/wdata      - register-file write port (registered)
//            commit_valid/pc/inst    - commit trace record (registered)
//            halt                    - sticky halt after ebreak commit
// Revision : 1.0 - initial release
// ============================================================================
module wb_commit_arbiter #(
    parameter int XLEN         = 64,
    parameter int STARVE_LIMIT = 4     // legal range 1..15 (4-bit counter)
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            exu_valid,
    output logic            exu_ready,
    input  logic [4:0]      exu_rd,
    input  logic            exu_wen,
    input  logic [XLEN-1:0] exu_data,
    input  logic [XLEN-1:0] exu_pc,
    input  logic [31:0]     exu_inst,
    input  logic            exu_break,

    input  logic            lsu_valid,
    output logic            lsu_ready,
    input  logic [4:0]      lsu_rd,
    input  logic            lsu_wen,
    input  logic [XLEN-1:0] lsu_data,
    input  logic [XLEN-1:0] lsu_pc,
    input  logic [31:0]     lsu_inst,

    output logic            rf_wen,
    output logic [4:0]      rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic            commit_valid,
    output logic [XLEN-1:0] commit_pc,
    output logic [31:0]     commit_inst,
    output logic            halt
);

    localparam logic [3:0] c_starve_limit = 4'(STARVE_LIMIT);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t            r_state;
    logic              r_halt;
    logic [3:0]        r_starve_cnt;

    logic              r_rf_wen;
    logic [4:0]        r_rf_waddr;
    logic [XLEN-1:0]   r_rf_wdata;
    logic              r_commit_valid;
    logic [XLEN-1:0]   r_commit_pc;
    logic [31:0]       r_commit_inst;

    logic              w_limit_hit;
    logic              w_exu_grant;
    logic              w_lsu_grant;
    logic              w_xfer;
    logic [4:0]        w_sel_rd;
    logic              w_sel_wen;
    logic [XLEN-1:0]   w_sel_data;
    logic [XLEN-1:0]   w_sel_pc;
    logic [31:0]       w_sel_inst;

    // ------------------------------------------------------------------
    // Grant: starved EXU first, then LSU, then EXU. Nothing is granted
    // once halted. Each grant is also the requester's ready.
    // ------------------------------------------------------------------
    assign w_limit_hit = (r_starve_cnt == c_starve_limit);
    assign w_exu_grant = exu_valid & ~r_halt & (w_limit_hit | ~lsu_valid);
    assign w_lsu_grant = lsu_valid & ~r_halt & ~(exu_valid & w_limit_hit);
    assign w_xfer      = w_exu_grant | w_lsu_grant;

    assign exu_ready = w_exu_grant;
    assign lsu_ready = w_lsu_grant;

    always_comb begin
        w_sel_rd   = lsu_rd;
        w_sel_wen  = lsu_wen;
        w_sel_data = lsu_data;
        w_sel_pc   = lsu_pc;
        w_sel_inst = lsu_inst;
        if (w_exu_grant) begin
            w_sel_rd   = exu_rd;
            w_sel_wen  = exu_wen;
            w_sel_data = exu_data;
            w_sel_pc   = exu_pc;
            w_sel_inst = exu_inst;
        end
    end

    // ------------------------------------------------------------------
    // Starvation counter: counts consecutive cycles EXU waits. Any cycle
    // where EXU is either idle or accepted restarts the count.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_starve_cnt <= 4'd0;
        end else if (exu_valid && !w_exu_grant) begin
            if (r_starve_cnt != c_starve_limit)
                r_starve_cnt <= r_starve_cnt + 4'd1;
        end else begin
            r_starve_cnt <= 4'd0;
        end
    end

    // ------------------------------------------------------------------
    // Output register. Strobes drop when idle; payload fields keep the
    // last committed values so the trace does not toggle needlessly.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rf_wen       <= 1'b0;
            r_rf_waddr     <= 5'd0;
            r_rf_wdata     <= '0;
            r_commit_valid <= 1'b0;
            r_commit_pc    <= '0;
            r_commit_inst  <= 32'd0;
        end else if (w_xfer) begin
            r_rf_wen       <= w_sel_wen & (w_sel_rd != 5'd0);  // x0 is never written
            r_rf_waddr     <= w_sel_rd;
            r_rf_wdata     <= w_sel_data;
            r_commit_valid <= 1'b1;
            r_commit_pc    <= w_sel_pc;
            r_commit_inst  <= w_sel_inst;
        end else begin
            r_rf_wen       <= 1'b0;
            r_commit_valid <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Halt FSM. The halt flag is loaded on the same edge as the ebreak's
    // commit record so both become visible together; only reset exits.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_RUN;
            r_halt  <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_exu_grant && exu_break) begin
                        r_state <= ST_HALT;
                        r_halt  <= 1'b1;
                    end
                end
                ST_HALT: begin
                    r_halt <= 1'b1;
                end
                default: begin
                    r_state <= ST_RUN;
                    r_halt  <= 1'b0;
                end
            endcase
        end
    end

    assign rf_wen       = r_rf_wen;
    assign rf_waddr     = r_rf_waddr;
    assign rf_wdata     = r_rf_wdata;
    assign commit_valid = r_commit_valid;
    assign commit_pc    = r_commit_pc;
    assign commit_inst  = r_commit_inst;
    assign halt         = r_halt;

endmodule
`default_nettype wire

// File: tb/tb_wb_commit_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_commit_arbiter
// Purpose  : Directed self-checking bench for wb_commit_arbiter: reset,
//            single write, collision, starvation, rd=0, async mid-stream
//            reset, ebreak halt and halt release by reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_commit_arbiter;

    localparam int XLEN = 64;

    logic            clk;
    logic            rst;
    logic            exu_valid, exu_ready, exu_wen, exu_break;
    logic [4:0]      exu_rd;
    logic [XLEN-1:0] exu_data, exu_pc;
    logic [31:0]     exu_inst;
    logic            lsu_valid, lsu_ready, lsu_wen;
    logic [4:0]      lsu_rd;
    logic [XLEN-1:0] lsu_data, lsu_pc;
    logic [31:0]     lsu_inst;
    logic            rf_wen, commit_valid, halt;
    logic [4:0]      rf_waddr;
    logic [XLEN-1:0] rf_wdata, commit_pc;
    logic [31:0]     commit_inst;

    int checks = 0;
    int errors = 0;

    wb_commit_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .exu_valid(exu_valid), .exu_ready(exu_ready), .exu_rd(exu_rd),
        .exu_wen(exu_wen), .exu_data(exu_data), .exu_pc(exu_pc),
        .exu_inst(exu_inst), .exu_break(exu_break),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd),
        .lsu_wen(lsu_wen), .lsu_data(lsu_data), .lsu_pc(lsu_pc),
        .lsu_inst(lsu_inst),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .commit_valid(commit_valid), .commit_pc(commit_pc),
        .commit_inst(commit_inst), .halt(halt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        exu_valid = 0; exu_rd = 0; exu_wen = 0; exu_data = 0; exu_pc = 0;
        exu_inst = 0; exu_break = 0;
        lsu_valid = 0; lsu_rd = 0; lsu_wen = 0; lsu_data = 0; lsu_pc = 0;
        lsu_inst = 0;

        // ---- reset state ----
        tick(); tick();
        chk("rst_rf_wen", rf_wen, 0);
        chk("rst_commit_valid", commit_valid, 0);
        chk("rst_halt", halt, 0);
        chk("rst_rf_waddr", rf_waddr, 0);
        chk("rst_commit_pc", commit_pc, 0);
        chk("rst_commit_inst", commit_inst, 0);

        // ---- single EXU write, presented right after release ----
        rst = 1'b0;
        exu_valid = 1; exu_rd = 5; exu_wen = 1; exu_data = 64'hDEAD_BEEF;
        exu_pc = 64'h8000_0000; exu_inst = 32'h0000_0013;
        #1;
        chk("single_exu_ready", exu_ready, 1);
        chk("single_lsu_ready", lsu_ready, 0);
        tick();
        exu_valid = 0;
        chk("single_rf_wen", rf_wen, 1);
        chk("single_rf_waddr", rf_waddr, 5);
        chk("single_rf_wdata", rf_wdata, 64'hDEAD_BEEF);
        chk("single_commit_valid", commit_valid, 1);
        chk("single_commit_pc", commit_pc, 64'h8000_0000);
        chk("single_commit_inst", commit_inst, 32'h0000_0013);
        tick();
        chk("idle_commit_valid", commit_valid, 0);
        chk("idle_rf_wen", rf_wen, 0);
        chk("idle_rf_waddr_hold", rf_waddr, 5);
        chk("idle_commit_pc_hold", commit_pc, 64'h8000_0000);

        // ---- collision: LSU first, EXU next cycle ----
        lsu_valid = 1; lsu_rd = 7; lsu_wen = 1; lsu_data = 64'h1111;
        lsu_pc = 64'h100; lsu_inst = 32'h0000_3003;
        exu_valid = 1; exu_rd = 8; exu_wen = 1; exu_data = 64'h2222;
        exu_pc = 64'h104; exu_inst = 32'h0000_0433;
        #1;
        chk("coll_lsu_ready", lsu_ready, 1);
        chk("coll_exu_ready", exu_ready, 0);
        tick();
        lsu_valid = 0;
        chk("coll_c1_pc", commit_pc, 64'h100);
        chk("coll_c1_waddr", rf_waddr, 7);
        #1;
        chk("coll_exu_ready2", exu_ready, 1);
        tick();
        exu_valid = 0;
        chk("coll_c2_pc", commit_pc, 64'h104);
        chk("coll_c2_waddr", rf_waddr, 8);
        chk("coll_c2_wdata", rf_wdata, 64'h2222);

        // ---- starvation: EXU stalls 4 cycles, wins the 5th ----
        lsu_valid = 1; lsu_pc = 64'h200; lsu_rd = 9;
        exu_valid = 1; exu_pc = 64'h300; exu_rd = 10;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("starve_exu_stall", exu_ready, 0);
            chk("starve_lsu_go", lsu_ready, 1);
            tick();
            chk("starve_lsu_commit_pc", commit_pc, 64'h200);
        end
        #1;
        chk("starve_exu_win", exu_ready, 1);
        chk("starve_lsu_stall", lsu_ready, 0);
        tick();
        exu_valid = 0;
        chk("starve_exu_commit_pc", commit_pc, 64'h300);
        chk("starve_exu_commit_waddr", rf_waddr, 10);
        #1;
        chk("starve_lsu_resume", lsu_ready, 1);
        tick();
        lsu_valid = 0;
        chk("starve_lsu_after_pc", commit_pc, 64'h200);

        // ---- rd = 0 with wen = 1 ----
        exu_valid = 1; exu_rd = 0; exu_wen = 1; exu_data = 64'h1234;
        exu_pc = 64'h400; exu_inst = 32'h0000_0000;
        tick();
        exu_valid = 0;
        chk("rd0_rf_wen", rf_wen, 0);
        chk("rd0_commit_valid", commit_valid, 1);
        chk("rd0_commit_pc", commit_pc, 64'h400);

        // ---- asynchronous reset while a commit is presented ----
        #2;
        rst = 1'b1;
        #1;
        chk("arst_commit_valid", commit_valid, 0);
        chk("arst_rf_wen", rf_wen, 0);
        chk("arst_rf_wdata", rf_wdata, 0);
        chk("arst_commit_pc", commit_pc, 0);
        chk("arst_halt", halt, 0);
        tick();
        rst = 1'b0;

        // ---- ebreak collides with LSU: LSU wins, ebreak commits later ----
        lsu_valid = 1; lsu_rd = 3; lsu_wen = 1; lsu_data = 64'h55;
        lsu_pc = 64'h500; lsu_inst = 32'h0000_2183;
        exu_valid = 1; exu_break = 1; exu_rd = 0; exu_wen = 0;
        exu_data = 64'h0; exu_pc = 64'h8000_0010; exu_inst = 32'h0010_0073;
        #1;
        chk("brk_first_lsu_ready", lsu_ready, 1);
        chk("brk_first_exu_ready", exu_ready, 0);
        tick();
        lsu_valid = 0;
        chk("brk_lsu_commit_pc", commit_pc, 64'h500);
        chk("brk_no_halt_yet", halt, 0);
        #1;
        chk("brk_exu_ready", exu_ready, 1);
        tick();
        exu_valid = 0; exu_break = 0;
        chk("brk_commit_valid", commit_valid, 1);
        chk("brk_commit_pc", commit_pc, 64'h8000_0010);
        chk("brk_commit_inst", commit_inst, 32'h0010_0073);
        chk("brk_rf_wen", rf_wen, 0);
        chk("brk_halt", halt, 1);

        // ---- halted: nothing is accepted ----
        exu_valid = 1; exu_pc = 64'h600; exu_rd = 4; exu_wen = 1;
        lsu_valid = 1; lsu_pc = 64'h700;
        for (int i = 0; i < 22; i++) begin
            #1;
            chk("halt_exu_ready", exu_ready, 0);
            chk("halt_lsu_ready", lsu_ready, 0);
            tick();
            chk("halt_commit_valid", commit_valid, 0);
            chk("halt_sticky", halt, 1);
        end

        // ---- reset clears halt ----
        exu_valid = 0; lsu_valid = 0;
        rst = 1'b1;
        #1;
        chk("halt_rst_clear", halt, 0);
        tick();
        rst = 1'b0;
        tick();
        chk("halt_after_release", halt, 0);
        lsu_valid = 1;
        #1;
        chk("post_halt_lsu_ready", lsu_ready, 1);
        tick();
        lsu_valid = 0;
        chk("post_halt_commit_pc", commit_pc, 64'h700);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_commit_arbiter.md
# wb_commit_arbiter

Shares the single general-purpose-register write port between the execute unit (ALU/CSR results) and the load/store unit (load returns), and produces one commit record per retired instruction for the simulation monitor. It sits between the EXU/LSU write-back stages and the register file plus commit-trace interface. It also halts the core when an `ebreak` commits. Arbitration uses fixed priority with an anti-starvation counter. The output stage is registered.

## Interface

- `XLEN`: default 64. Data and PC width.
- `STARVE_LIMIT`: default 4. Consecutive stalled EXU cycles after which EXU takes priority. Range 1..15.
- `clk`, input, 1. The only clock.
- `rst`, input, 1. Asynchronous, active-high reset.
- `exu_valid`, `lsu_valid`, input, 1 each. Request valid.
- `exu_ready`, `lsu_ready`, output, 1 each. Request accepted this cycle.
- `exu_rd`, `lsu_rd`, input, 5 each. Destination register.
- `exu_wen`, `lsu_wen`, input, 1 each. Instruction writes rd.
- `exu_data`, `lsu_data`, input, XLEN each. Write data.
- `exu_pc`, `lsu_pc`, input, XLEN each. Instruction PC.
- `exu_inst`, `lsu_inst`, input, 32 each. Instruction word.
- `exu_break`, input, 1. Instruction is `ebreak`. Only EXU issues `ebreak`.
- `rf_wen`, output, 1. Register-file write enable.
- `rf_waddr`, output, 5. Write address.
- `rf_wdata`, output, XLEN. Write data.
- `commit_valid`, output, 1. One instruction retired this cycle.
- `commit_pc`, output, XLEN. PC of the retired instruction.
- `commit_inst`, output, 32. Instruction word of the retired instruction.
- `halt`, output, 1. Sticky. Core stopped by `ebreak`.

## Operation

- **Handshake.** Valid/ready. A requester holds `valid` and its payload stable until `ready`=1. Transfer happens on a cycle with `valid & ready`. `ready` depends combinationally on both valids, the starvation counter and the halt state. The output register never back-pressures.
- **Grant, at most one per cycle.**
  - If `starve_cnt == STARVE_LIMIT` and `exu_valid`, grant EXU.
  - Otherwise, if `lsu_valid`, grant LSU.
  - Otherwise, if `exu_valid`, grant EXU.
- **Starvation counter.** Width 4 bits.
  - Increments, saturating at `STARVE_LIMIT`, on each cycle with `exu_valid & ~exu_ready`.
  - Clears to 0 on an EXU transfer, or on a cycle with `exu_valid`=0.
- **Output register.** Loaded every cycle.
  - On a transfer: `commit_valid`=1, `commit_pc`/`commit_inst` from the winner, `rf_waddr`/`rf_wdata` from the winner, `rf_wen` = winner wen & (rd != 0).
  - With no transfer: `commit_valid`=0 and `rf_wen`=0; the other fields hold their previous values.
- **Halt FSM.** States RUN and HALT.
  - RUN→HALT on an EXU transfer with `exu_break`=1.
  - HALT is left only by `rst`.
  - In HALT, `exu_ready`=`lsu_ready`=0 and `halt`=1.
  - The `ebreak` itself still commits normally: `commit_valid`=1, `rf_wen`=0 unless its wen is set.

## Timing

- Latency is 1 cycle: a transfer at edge N appears on `rf_*`/`commit_*` after edge N, valid for exactly one cycle.
- `halt` rises in the same cycle the `ebreak` commit is presented: both come from the register load at edge N.
- `ready` is 0 for both requesters from the cycle after that edge onward.
- Throughput is one commit per cycle. The loser of simultaneous requests is accepted no earlier than the next cycle.
- Reset (asynchronous, applies immediately, mid-operation included):
  - `rf_wen`, `commit_valid` and `halt` go to 0.
  - `rf_waddr`, `rf_wdata`, `commit_pc` and `commit_inst` go to 0.
  - `starve_cnt` goes to 0 and the FSM goes to RUN.
  - An in-flight registered commit is discarded.
- Boundary rules:
  - rd=0 with wen=1 gives `rf_wen`=0 and `commit_valid`=1.
  - Simultaneous `exu_break` and `lsu_valid` with counter below limit: LSU wins, and the `ebreak` commits later.
  - A request presented while HALT stays unaccepted indefinitely.

## Test plan

- **Reset.** Assert `rst` mid-stream with `commit_valid`=1 → all outputs 0 asynchronously; `halt`=0 after release; the first request after release is accepted with 0 extra cycles.
- **Single EXU write.** EXU rd=5, data=0xDEAD_BEEF, pc=0x8000_0000, wen=1 → next cycle `rf_wen`=1, `rf_waddr`=5, `rf_wdata`=0xDEADBEEF, `commit_valid`=1, `commit_pc`=0x80000000.
- **Collision.** Both valid in one cycle → LSU committed in cycle 1, EXU in cycle 2, `exu_ready` low for exactly 1 cycle.
- **Starvation.** STARVE_LIMIT=4, LSU valid continuously, EXU valid → EXU stalls 4 cycles, is accepted on the 5th, and LSU is stalled for that one cycle.
- **rd=0.** EXU rd=0, wen=1, data=0x1234 → `rf_wen`=0, `commit_valid`=1.
- **ebreak.** EXU `exu_break`=1, pc=0x8000_0010 → commit with that pc and `halt`=1 in the same cycle; subsequent LSU/EXU requests see `ready`=0 for 20+ cycles; `rst` clears `halt`.
